// File: rtl/nn_layer_engine.sv
// nn_layer_engine: single fully-connected layer with a sequential multiply-accumulate datapath.
// Signed fixed-point words are DATA_W bits wide with FRAC_W fractional bits.
// One product is computed per cycle, and each neuron result passes through ReLU before it is stored.
// Optional macro NN_SATURATE_EN clamps each result to [0, 2^(DATA_W-1)-1].
// Without the macro, the low DATA_W bits of the result are kept (wrap).
module nn_layer_engine #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned FRAC_W = 4,
    parameter int unsigned N_IN   = 2,
    parameter int unsigned N_OUT  = 1,
    localparam int unsigned N_W   = N_OUT * (N_IN + 1),
    localparam int unsigned WA_W  = (N_W > 1) ? $clog2(N_W) : 1,
    localparam int unsigned OA_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fill,
    input  logic              fill_valid,
    input  logic [DATA_W-1:0] fill_data,
    output logic              ack_fill,
    input  logic              w_we,
    input  logic [WA_W-1:0]   w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              req,
    output logic              ack_network,
    input  logic [OA_W-1:0]   out_addr,
    output logic [DATA_W-1:0] out_data
);

    localparam int unsigned IW    = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int unsigned ACC_W = 2 * DATA_W + $clog2(N_IN) + 1;

    typedef enum logic [2:0] {IDLE, FILL, MAC, STORE, DONE} state_t;

    state_t                    state;
    logic [IW-1:0]             cnt_i;
    logic [OA_W-1:0]           cnt_j;
    logic signed [ACC_W-1:0]   acc;

    logic signed [DATA_W-1:0]  inbuf  [N_IN];
    logic signed [DATA_W-1:0]  wmem   [N_W];
    logic        [DATA_W-1:0]  outram [N_OUT];

    logic [WA_W-1:0]           wsel_c;
    logic [WA_W-1:0]           bsel_c;
    logic [OA_W-1:0]           nxt_j_c;
    logic signed [2*DATA_W-1:0] prod_c;
    logic [DATA_W-1:0]         res_c;

    // Weight index of the current product and bias index of the neuron about to start
    always_comb begin
        nxt_j_c = '0;
        if (state != IDLE) begin
            nxt_j_c = OA_W'(cnt_j + 1'b1);
        end
        wsel_c = WA_W'(32'(cnt_j) * 32'(N_IN + 1) + 32'(cnt_i));
        bsel_c = WA_W'(32'(nxt_j_c) * 32'(N_IN + 1) + 32'(N_IN));
        prod_c = inbuf[cnt_i] * wmem[wsel_c];
    end

    // ReLU of acc >>> FRAC_W followed by quantisation to DATA_W
    always_comb begin
        res_c = '0;
        if (!acc[ACC_W-1]) begin
`ifdef NN_SATURATE_EN
            if (|acc[ACC_W-2:FRAC_W+DATA_W-1]) begin
                res_c = {1'b0, {(DATA_W-1){1'b1}}};
            end else begin
                res_c = acc[FRAC_W +: DATA_W];
            end
`else
            res_c = acc[FRAC_W +: DATA_W];
`endif
        end
    end

    // Control FSM, accumulator and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt_i       <= '0;
            cnt_j       <= '0;
            acc         <= '0;
            ack_fill    <= 1'b0;
            ack_network <= 1'b0;
            out_data    <= '0;
        end else begin
            ack_fill    <= 1'b0;
            ack_network <= 1'b0;
            out_data    <= (32'(out_addr) < N_OUT) ? outram[out_addr] : '0;
            case (state)
                IDLE: begin
                    cnt_i <= '0;
                    cnt_j <= '0;
                    if (fill) begin
                        state <= FILL;
                    end else if (req) begin
                        state <= MAC;
                        acc   <= ACC_W'(wmem[bsel_c]) <<< FRAC_W;
                    end
                end
                FILL: begin
                    if (fill_valid) begin
                        if (cnt_i == IW'(N_IN - 1)) begin
                            cnt_i    <= '0;
                            ack_fill <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            cnt_i <= IW'(cnt_i + 1'b1);
                        end
                    end
                end
                MAC: begin
                    acc <= acc + ACC_W'(prod_c);
                    if (cnt_i == IW'(N_IN - 1)) begin
                        cnt_i <= '0;
                        state <= STORE;
                    end else begin
                        cnt_i <= IW'(cnt_i + 1'b1);
                    end
                end
                STORE: begin
                    if (cnt_j == OA_W'(N_OUT - 1)) begin
                        state <= DONE;
                    end else begin
                        cnt_j <= nxt_j_c;
                        acc   <= ACC_W'(wmem[bsel_c]) <<< FRAC_W;
                        state <= MAC;
                    end
                end
                DONE: begin
                    ack_network <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memories keep their contents across reset
    always_ff @(posedge clk) begin
        if (state == FILL && fill_valid) begin
            inbuf[cnt_i] <= fill_data;
        end
        if (state == IDLE && w_we && (32'(w_addr) < N_W)) begin
            wmem[w_addr] <= w_data;
        end
        if (state == STORE) begin
            outram[cnt_j] <= res_c;
        end
    end

endmodule
